// File: rtl/cia_eclk_sequencer.sv
// E-clock divider and CIA bus-cycle sequencer (U409): REQ/ACK cycles aligned to E periods.
// Define CIA_TURBO_EN to add the TURBO port and a shorter E period selected at each wrap.
module cia_eclk_sequencer #(
    parameter int DIV_N     = 10,
    parameter int HIGH_N    = 4,
    parameter int CS_CNT    = 3,
    parameter int NCH       = 2,
    parameter int TURBO_DIV = 4,
    parameter int TURBO_HI  = 2
) (
    input  logic           CLK7,
    input  logic           RESETn,
    input  logic [NCH-1:0] CIA_SPACE,
    input  logic           CYCLE_REQ,
`ifdef CIA_TURBO_EN
    input  logic           TURBO,
`endif
    output logic           CLKCIA,
    output logic [NCH-1:0] CIA_ENABLE,
    output logic           CIA_ACK,
    output logic           E_WRAP
);

    localparam int CW = $clog2(DIV_N);
    localparam int T_CS_MAX = TURBO_DIV - TURBO_HI - 1;

    localparam logic [CW-1:0] N_LAST = CW'(DIV_N - 1);
    localparam logic [CW-1:0] T_LAST = CW'(TURBO_DIV - 1);
    localparam logic [CW-1:0] N_ETHR = CW'(DIV_N - HIGH_N);
    localparam logic [CW-1:0] T_ETHR = CW'(TURBO_DIV - TURBO_HI);
    localparam logic [CW-1:0] N_CS   = CW'(CS_CNT);
    localparam logic [CW-1:0] T_CS   = CW'((CS_CNT < T_CS_MAX) ? CS_CNT : T_CS_MAX);

    if (DIV_N < 4) begin : g_bad_div
        $error("DIV_N must be at least 4");
    end
    if (HIGH_N < 1 || HIGH_N >= DIV_N - 1) begin : g_bad_high
        $error("HIGH_N must be in 1..DIV_N-2");
    end
    if (CS_CNT < 0 || CS_CNT >= DIV_N - HIGH_N) begin : g_bad_cs
        $error("CS_CNT must be below DIV_N-HIGH_N");
    end
`ifdef CIA_TURBO_EN
    if (TURBO_HI < 1 || TURBO_HI >= TURBO_DIV - 1) begin : g_bad_thi
        $error("TURBO_HI must be in 1..TURBO_DIV-2");
    end
    if (TURBO_DIV > DIV_N) begin : g_bad_tdiv
        $error("TURBO_DIV must not exceed DIV_N");
    end
`endif

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [CW-1:0]   last_cnt, e_thr, cs_cnt;
    logic            at_last, at_cs;
    logic            turbo_reg;
    logic            e_clk_reg, e_wrap_reg, ack_reg;
    logic            ack_next, en_window, start;
    logic [NCH-1:0]  mask_reg, mask_next;
    logic [NCH-1:0]  enable_reg, enable_next;

    // Period selection follows the turbo flag captured at the previous wrap.
    always_comb begin
        last_cnt = turbo_reg ? T_LAST : N_LAST;
        e_thr    = turbo_reg ? T_ETHR : N_ETHR;
        cs_cnt   = turbo_reg ? T_CS   : N_CS;
    end

    assign at_last  = (cnt_reg == last_cnt);
    assign at_cs    = (cnt_reg == cs_cnt);
    assign cnt_next = at_last ? '0 : cnt_reg + CW'(1);

`ifdef CIA_TURBO_EN
    always_ff @(posedge CLK7 or negedge RESETn) begin
        if (!RESETn) begin
            turbo_reg <= 1'b0;
        end else if (at_last) begin
            turbo_reg <= TURBO;
        end
    end
`else
    assign turbo_reg = 1'b0;
`endif

    always_ff @(posedge CLK7 or negedge RESETn) begin
        if (!RESETn) begin
            cnt_reg    <= '0;
            e_clk_reg  <= 1'b0;
            e_wrap_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            e_clk_reg  <= (cnt_next >= e_thr);
            e_wrap_reg <= (cnt_next == '0);
        end
    end

    always_ff @(posedge CLK7 or negedge RESETn) begin
        if (!RESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A dropped request always wins, so an abandoned cycle never ACKs.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (CYCLE_REQ) state_next = at_cs ? ACTIVE : ARMED;
            ARMED:   if (!CYCLE_REQ) state_next = IDLE;
                     else if (at_cs) state_next = ACTIVE;
            ACTIVE:  if (!CYCLE_REQ) state_next = IDLE;
                     else if (at_last) state_next = DONE;
            DONE:    if (!CYCLE_REQ) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start     = (state_reg == IDLE || state_reg == ARMED) && (state_next == ACTIVE);
        mask_next = start ? CIA_SPACE : mask_reg;
        ack_next  = (state_reg == ACTIVE) && (state_next == DONE);
        en_window = (state_next == ACTIVE) || ack_next;
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_enable
        assign enable_next[gi] = en_window & mask_next[gi];
    end

    always_ff @(posedge CLK7 or negedge RESETn) begin
        if (!RESETn) begin
            mask_reg   <= '0;
            enable_reg <= '0;
            ack_reg    <= 1'b0;
        end else begin
            mask_reg   <= mask_next;
            enable_reg <= enable_next;
            ack_reg    <= ack_next;
        end
    end

    assign CLKCIA     = e_clk_reg;
    assign E_WRAP     = e_wrap_reg;
    assign CIA_ENABLE = enable_reg;
    assign CIA_ACK    = ack_reg;

endmodule

// File: tb/tb_cia_eclk_sequencer.sv
// Random REQ/ACK traffic against a cycle-indexed expectation model plus E-clock timing checks.
`timescale 1ns/1ps
module tb_cia_eclk_sequencer;

    localparam int DIV_N  = 10;
    localparam int HIGH_N = 4;
    localparam int CS_CNT = 3;
    localparam int NCH    = 2;

    logic           CLK7 = 1'b0;
    logic           RESETn = 1'b0;
    logic [NCH-1:0] CIA_SPACE = '0;
    logic           CYCLE_REQ = 1'b0;
    logic           CLKCIA, CIA_ACK, E_WRAP;
    logic [NCH-1:0] CIA_ENABLE;
`ifdef CIA_TURBO_EN
    logic           TURBO = 1'b0;
`endif

    cia_eclk_sequencer #(
        .DIV_N(DIV_N), .HIGH_N(HIGH_N), .CS_CNT(CS_CNT), .NCH(NCH),
        .TURBO_DIV(4), .TURBO_HI(2)
    ) dut (
        .CLK7(CLK7),
        .RESETn(RESETn),
        .CIA_SPACE(CIA_SPACE),
        .CYCLE_REQ(CYCLE_REQ),
`ifdef CIA_TURBO_EN
        .TURBO(TURBO),
`endif
        .CLKCIA(CLKCIA),
        .CIA_ENABLE(CIA_ENABLE),
        .CIA_ACK(CIA_ACK),
        .E_WRAP(E_WRAP)
    );

    always #5 CLK7 = ~CLK7;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // cyc = CLK7 edges since reset release, so the E phase is simply cyc mod DIV_N.
    always @(posedge CLK7) begin
        if (!RESETn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct { int cyc; logic [NCH-1:0] mask; } ack_t;
    ack_t           ackq[$];
    logic [NCH-1:0] exp_en[int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc=%0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares every cycle and retires scoreboard entries on ACK.
    initial begin : monitor
        int   ph;
        logic exp_ack;
        forever begin
            @(negedge CLK7);
            if (RESETn && cyc > 0) begin
                ph = cyc % DIV_N;
                check("clkcia", CLKCIA, ph >= DIV_N - HIGH_N);
                check("e_wrap", E_WRAP, ph == 0);
                check("enable", CIA_ENABLE, exp_en.exists(cyc) ? exp_en[cyc] : '0);
                exp_ack = (ackq.size() > 0) && (ackq[0].cyc == cyc);
                check("ack", CIA_ACK, exp_ack);
                if (exp_ack) begin
                    check("ack_mask", CIA_ENABLE, ackq[0].mask);
                    void'(ackq.pop_front());
                end else if (ackq.size() > 0 && ackq[0].cyc < cyc) begin
                    void'(ackq.pop_front());
                end
            end
        end
    end

    // One bus cycle: rise REQ (optionally at a given E phase), then drop it after ACK+hold or as an abort.
    task automatic issue(input int phase, input logic [NCH-1:0] mask, input int hold, input bit abort);
        int n, c, b, act_base, a, d;
        @(negedge CLK7);
        if (phase >= 0) while (cyc % DIV_N != phase) @(negedge CLK7);
        n = cyc;
        c = n % DIV_N;
        b = n - c;
        act_base = (c <= CS_CNT) ? b : b + DIV_N;
        a = act_base + DIV_N;
        d = abort ? n + 1 + int'($urandom_range(0, a - n - 2)) : a + hold;
        for (int k = act_base + CS_CNT + 1; k <= a; k++)
            if (k <= d) exp_en[k] = mask;
        if (!abort) ackq.push_back('{cyc: a, mask: mask});
        CYCLE_REQ = 1'b1;
        CIA_SPACE = mask;
        while (cyc < d) @(negedge CLK7);
        CYCLE_REQ = 1'b0;
        CIA_SPACE = NCH'($urandom);
        $display("txn req_cyc=%0d cnt=%0d mask=%b abort=%0d ack_cyc=%0d drop_cyc=%0d",
                 n, c, mask, abort, abort ? -1 : a, d);
    endtask

    int             ph_t[5] = '{1, 4, -1, 2, -1};
    logic [NCH-1:0] mk_t[5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11};
    int             hd_t[5] = '{0, 2, 41, 0, 0};
    bit             ab_t[5] = '{0, 0, 0, 0, 1};

    initial begin : driver
        int b;
        repeat (3) @(negedge CLK7);
        check("rst_clkcia", CLKCIA, 0);
        check("rst_enable", CIA_ENABLE, 0);
        check("rst_ack", CIA_ACK, 0);
        check("rst_e_wrap", E_WRAP, 0);
        RESETn = 1'b1;
        repeat (30) @(negedge CLK7);

        for (int i = 0; i < 5; i++) issue(ph_t[i], mk_t[i], hd_t[i], ab_t[i]);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 20)) @(negedge CLK7);
            issue(-1, NCH'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 45)) : int'($urandom_range(0, 3)),
                  $urandom_range(0, 4) == 0);
        end
        repeat (25) @(negedge CLK7);
        check("ackq_empty", ackq.size(), 0);

        // Reset in the middle of an active cycle must clear everything at once and suppress the ACK.
        @(negedge CLK7);
        while (cyc % DIV_N != 0) @(negedge CLK7);
        b = cyc;
        for (int k = b + CS_CNT + 1; k <= b + DIV_N; k++) exp_en[k] = 2'b11;
        ackq.push_back('{cyc: b + DIV_N, mask: 2'b11});
        CYCLE_REQ = 1'b1;
        CIA_SPACE = 2'b11;
        while (cyc != b + 7) @(negedge CLK7);
        #2;
        RESETn = 1'b0;
        CYCLE_REQ = 1'b0;
        ackq.delete();
        exp_en.delete();
        #1;
        check("abort_clkcia", CLKCIA, 0);
        check("abort_enable", CIA_ENABLE, 0);
        check("abort_ack", CIA_ACK, 0);
        check("abort_e_wrap", E_WRAP, 0);
        $display("txn reset asserted at cnt=7 of active cycle");
        repeat (3) @(negedge CLK7);
        RESETn = 1'b1;
        repeat (30) @(negedge CLK7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
